// File: rtl/alu_pwm_pkg.sv
// Shared types for the ALU/PWM operation controller.
package alu_pwm_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD    = 3'b000,
    OP_SUB    = 3'b001,
    OP_AND    = 3'b010,
    OP_OR     = 3'b011,
    OP_XOR    = 3'b100,
    OP_SHL    = 3'b101,
    OP_SHR    = 3'b110,
    OP_PASS_A = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    EXEC  = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic z;
    logic n;
    logic o;
    logic c;
  } flags_t;

endpackage

// File: rtl/pwm_core.sv
// Free-running PWM generator; the duty shadow only reloads at the counter wrap.
module pwm_core #(
  parameter int unsigned WIDTH    = 2,
  parameter int unsigned PWM_BITS = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] level,
  output logic             pwm_out
);

  localparam int unsigned SHIFT = PWM_BITS - WIDTH;

  logic [PWM_BITS-1:0] cnt_q;
  logic [PWM_BITS-1:0] shadow_q;
  logic [PWM_BITS-1:0] target_c;
  logic                pwm_q;

  // Result scaled to full counter range.
  assign target_c = PWM_BITS'(level) << SHIFT;

  // Counter, period-aligned shadow load and registered compare.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      cnt_q <= cnt_q + PWM_BITS'(1);
      if (cnt_q == '1) begin
        shadow_q <= target_c;
      end
      pwm_q <= (cnt_q < shadow_q);
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: rtl/alu_pwm_controller.sv
// Confirm-gated ALU with registered result/flags driving a PWM motor output.
module alu_pwm_controller
  import alu_pwm_pkg::*;
#(
  parameter int unsigned WIDTH       = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PWM_BITS    = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             confirm_btn,
  input  logic             handshake,
  input  logic             clear,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_o,
  output logic             flag_c,
  output logic             result_valid,
  output logic             busy,
  output logic             pwm_out
);

  localparam int unsigned MSB = WIDTH - 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   confirm_edge_c;

  state_e                 state_q;
  op_e                    op_q;
  logic [WIDTH-1:0]       a_q;
  logic [WIDTH-1:0]       b_q;
  logic [WIDTH-1:0]       result_q;
  flags_t                 flags_q;
  logic                   result_valid_q;
  logic                   busy_q;

  logic [WIDTH:0]         sum_c;
  logic [WIDTH:0]         diff_c;
  logic [WIDTH-1:0]       alu_result_d;
  flags_t                 alu_flags_d;

  // Button synchroniser plus one delayed copy for rising-edge detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], confirm_btn};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign confirm_edge_c = sync_q[SYNC_STAGES-1] & ~prev_q;

  assign sum_c  = {1'b0, a_q} + {1'b0, b_q};
  assign diff_c = {1'b0, a_q} - {1'b0, b_q};

  // ALU on the captured operands; carry doubles as borrow for SUB.
  always_comb begin
    alu_result_d = '0;
    alu_flags_d  = '0;
    unique case (op_q)
      OP_ADD: begin
        alu_result_d  = sum_c[MSB:0];
        alu_flags_d.c = sum_c[WIDTH];
        alu_flags_d.o = (a_q[MSB] == b_q[MSB]) && (sum_c[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        alu_result_d  = diff_c[MSB:0];
        alu_flags_d.c = diff_c[WIDTH];
        alu_flags_d.o = (a_q[MSB] != b_q[MSB]) && (diff_c[MSB] != a_q[MSB]);
      end
      OP_AND:    alu_result_d = a_q & b_q;
      OP_OR:     alu_result_d = a_q | b_q;
      OP_XOR:    alu_result_d = a_q ^ b_q;
      OP_SHL: begin
        alu_result_d  = {a_q[MSB-1:0], 1'b0};
        alu_flags_d.c = a_q[MSB];
      end
      OP_SHR: begin
        alu_result_d  = {1'b0, a_q[MSB:1]};
        alu_flags_d.c = a_q[0];
      end
      OP_PASS_A: alu_result_d = a_q;
    endcase
    alu_flags_d.z = (alu_result_d == '0);
    alu_flags_d.n = alu_result_d[MSB];
  end

  // Operation sequencer; clear outranks handshake loss, which outranks the FSM.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      op_q           <= OP_ADD;
      a_q            <= '0;
      b_q            <= '0;
      result_q       <= '0;
      flags_q        <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      if (clear) begin
        result_q <= '0;
        flags_q  <= '0;
        busy_q   <= 1'b0;
        state_q  <= handshake ? READY : IDLE;
      end else if (!handshake) begin
        busy_q  <= 1'b0;
        state_q <= IDLE;
      end else begin
        unique case (state_q)
          IDLE: state_q <= READY;
          READY: begin
            if (confirm_edge_c) begin
              op_q    <= op_e'(op);
              a_q     <= operand_a;
              b_q     <= operand_b;
              busy_q  <= 1'b1;
              state_q <= EXEC;
            end
          end
          EXEC: begin
            result_q       <= alu_result_d;
            flags_q        <= alu_flags_d;
            result_valid_q <= 1'b1;
            state_q        <= DONE;
          end
          DONE: begin
            busy_q  <= 1'b0;
            state_q <= READY;
          end
        endcase
      end
    end
  end

  pwm_core #(
    .WIDTH    (WIDTH),
    .PWM_BITS (PWM_BITS)
  ) u_pwm_core (
    .clock   (clock),
    .reset_n (reset_n),
    .level   (result_q),
    .pwm_out (pwm_out)
  );

  assign result       = result_q;
  assign flag_z       = flags_q.z;
  assign flag_n       = flags_q.n;
  assign flag_o       = flags_q.o;
  assign flag_c       = flags_q.c;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_alu_pwm_controller.sv
// Bench for alu_pwm_controller: WIDTH=2 and WIDTH=4 instances run in lockstep.
module tb_alu_pwm_controller;

  localparam int unsigned S  = 2;
  localparam int unsigned PB = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn = 1'b0;
  logic       hs = 1'b0;
  logic       clr = 1'b0;
  logic [2:0] op = 3'd0;
  logic [1:0] a2 = '0, b2 = '0;
  logic [3:0] a4 = '0, b4 = '0;

  logic [1:0] r2;
  logic [3:0] r4;
  logic z2, n2, o2, c2, rv2, busy2, pwm2;
  logic z4, n4, o4, c4, rv4, busy4, pwm4;
  logic [5:0] obs2;
  logic [7:0] obs4;

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned edges;

  assign obs2 = {z2, n2, o2, c2, r2};
  assign obs4 = {z4, n4, o4, c4, r4};

  always #5 clk = ~clk;

  // Edges since reset release; equals the PWM counter position.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  alu_pwm_controller #(.WIDTH(2), .SYNC_STAGES(S), .PWM_BITS(PB)) u_w2 (
    .clock(clk), .reset_n(rst_n), .confirm_btn(btn), .handshake(hs), .clear(clr),
    .op(op), .operand_a(a2), .operand_b(b2), .result(r2),
    .flag_z(z2), .flag_n(n2), .flag_o(o2), .flag_c(c2),
    .result_valid(rv2), .busy(busy2), .pwm_out(pwm2));

  alu_pwm_controller #(.WIDTH(4), .SYNC_STAGES(S), .PWM_BITS(PB)) u_w4 (
    .clock(clk), .reset_n(rst_n), .confirm_btn(btn), .handshake(hs), .clear(clr),
    .op(op), .operand_a(a4), .operand_b(b4), .result(r4),
    .flag_z(z4), .flag_n(n4), .flag_o(o4), .flag_c(c4),
    .result_valid(rv4), .busy(busy4), .pwm_out(pwm4));

  // Arithmetic reference: returns {z,n,o,c} in [19:16], result in [15:0].
  function automatic logic [19:0] model(input int w, input int opv, input int a, input int b);
    int m, sa, sb, ss, r;
    bit c, o;
    m = 1 << w;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    c = 0; o = 0; r = 0; ss = 0;
    case (opv)
      0: begin r = (a + b) % m; c = (a + b) >= m; ss = sa + sb; o = (ss > m/2 - 1) || (ss < -(m/2)); end
      1: begin r = (a - b + m) % m; c = a < b; ss = sa - sb; o = (ss > m/2 - 1) || (ss < -(m/2)); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = (a * 2) % m; c = a >= m / 2; end
      6: begin r = a / 2; c = (a % 2) == 1; end
      default: r = a;
    endcase
    model = {(r == 0), (r >= m / 2), o, c, 16'(r)};
  endfunction

  // Press the button and wait (bounded) for the result pulse, then release.
  task automatic press_wait(output bit seen);
    seen = 0;
    @(negedge clk); btn = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (rv2) begin seen = 1; break; end
    end
    @(negedge clk); btn = 1'b0;
    repeat (S + 2) @(negedge clk);
  endtask

  // Advance to the sample that closes a PWM period (bounded).
  task automatic wait_boundary(output bit found);
    found = 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (edges % 256 == 0) begin found = 1; break; end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({obs2, rv2, busy2, pwm2} !== 9'd0) begin
      n_fail++; $display("FAIL reset_w2 got %b exp 0", {obs2, rv2, busy2, pwm2});
    end
    n_checks++;
    if ({obs4, rv4, busy4, pwm4} !== 11'd0) begin
      n_fail++; $display("FAIL reset_w4 got %b exp 0", {obs4, rv4, busy4, pwm4});
    end
    rst_n = 1'b1;
    hs = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_latency;
    logic [19:0] m2, m4;
    op = 3'd0; a2 = 2'd3; b2 = 2'd1; a4 = 4'd3; b4 = 4'd1;
    m2 = model(2, 0, 3, 1);
    m4 = model(4, 0, 3, 1);
    @(negedge clk); btn = 1'b1;
    for (int k = 1; k <= int'(S) + 3; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (rv2 !== 1'(k == int'(S) + 2)) begin
        n_fail++; $display("FAIL latency_rv edge %0d got %b", k, rv2);
      end
      n_checks++;
      if (busy2 !== 1'(k == int'(S) + 1 || k == int'(S) + 2)) begin
        n_fail++; $display("FAIL latency_busy edge %0d got %b", k, busy2);
      end
    end
    @(negedge clk); btn = 1'b0;
    repeat (S + 2) @(negedge clk);
    n_checks++;
    if (obs2 !== {m2[19:16], m2[1:0]}) begin
      n_fail++; $display("FAIL add_w2 got %b exp %b", obs2, {m2[19:16], m2[1:0]});
    end
    n_checks++;
    if (obs4 !== {m4[19:16], m4[3:0]}) begin
      n_fail++; $display("FAIL add_w4 got %b exp %b", obs4, {m4[19:16], m4[3:0]});
    end
  endtask

  task automatic test_sub;
    bit seen;
    logic [19:0] m4;
    int va [2] = '{2, 7};
    int vb [2] = '{5, 8};
    op = 3'd1;
    for (int i = 0; i < 2; i++) begin
      a4 = 4'(va[i]); b4 = 4'(vb[i]);
      m4 = model(4, 1, va[i], vb[i]);
      press_wait(seen);
      n_checks++;
      if (!seen) begin n_fail++; $display("FAIL sub_timeout case %0d got no result_valid", i); end
      n_checks++;
      if (obs4 !== {m4[19:16], m4[3:0]}) begin
        n_fail++; $display("FAIL sub_w4 case %0d got %b exp %b", i, obs4, {m4[19:16], m4[3:0]});
      end
    end
  endtask

  task automatic test_random;
    bit seen;
    logic [19:0] m2, m4;
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      a2 = 2'($urandom); b2 = 2'($urandom);
      a4 = 4'($urandom); b4 = 4'($urandom);
      m2 = model(2, int'(op), int'(a2), int'(b2));
      m4 = model(4, int'(op), int'(a4), int'(b4));
      press_wait(seen);
      n_checks++;
      if (!seen) begin n_fail++; $display("FAIL rand_timeout iter %0d", i); end
      n_checks++;
      if (obs2 !== {m2[19:16], m2[1:0]}) begin
        n_fail++; $display("FAIL rand_w2 op %0d a %0d b %0d got %b exp %b", op, a2, b2, obs2, {m2[19:16], m2[1:0]});
      end
      n_checks++;
      if (obs4 !== {m4[19:16], m4[3:0]}) begin
        n_fail++; $display("FAIL rand_w4 op %0d a %0d b %0d got %b exp %b", op, a4, b4, obs4, {m4[19:16], m4[3:0]});
      end
    end
  endtask

  task automatic test_hold_and_handshake;
    int pulses, busy_seen;
    bit seen, got_busy;
    logic [19:0] m2;
    // Held button: one accepted edge only.
    pulses = 0;
    @(negedge clk); btn = 1'b1;
    repeat (100) begin @(posedge clk); #1; pulses += int'(rv2); end
    @(negedge clk); btn = 1'b0;
    repeat (S + 2) @(negedge clk);
    n_checks++;
    if (pulses != 1) begin n_fail++; $display("FAIL hold_pulses got %0d exp 1", pulses); end
    // Second tap lands while busy and is dropped.
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); btn = (k == 0 || k == 2);
      @(posedge clk); #1; pulses += int'(rv2);
    end
    n_checks++;
    if (pulses != 1) begin n_fail++; $display("FAIL busy_tap_pulses got %0d exp 1", pulses); end
    // No operations without the link.
    hs = 1'b0; pulses = 0; busy_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); btn = (k < 3);
      @(posedge clk); #1; pulses += int'(rv2); busy_seen += int'(busy2);
    end
    n_checks++;
    if (pulses != 0 || busy_seen != 0) begin
      n_fail++; $display("FAIL nohs_activity got rv %0d busy %0d exp 0 0", pulses, busy_seen);
    end
    hs = 1'b1;
    repeat (3) @(negedge clk);
    // Link drop during EXEC keeps the previous result.
    op = 3'd7; a2 = 2'd1; a4 = 4'd6;
    m2 = model(2, 7, 1, 0);
    press_wait(seen);
    a2 = 2'd2; a4 = 4'd9;
    @(negedge clk); btn = 1'b1;
    got_busy = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (busy2) begin got_busy = 1; break; end
    end
    hs = 1'b0; pulses = 0; busy_seen = 0;
    repeat (8) begin @(posedge clk); #1; pulses += int'(rv2); busy_seen += int'(busy2); end
    n_checks++;
    if (!got_busy || pulses != 0 || busy_seen != 0) begin
      n_fail++; $display("FAIL hsdrop_abandon got busy_seen %0b rv %0d busy %0d", got_busy, pulses, busy_seen);
    end
    n_checks++;
    if (obs2 !== {m2[19:16], m2[1:0]}) begin
      n_fail++; $display("FAIL hsdrop_retain got %b exp %b", obs2, {m2[19:16], m2[1:0]});
    end
    @(negedge clk); btn = 1'b0; hs = 1'b1;
    repeat (S + 3) @(negedge clk);
  endtask

  task automatic test_pwm;
    bit seen, found;
    int hi2, hi4;
    int old2, old4, new2, new4;
    op = 3'd7; a2 = 2'd2; a4 = 4'd5;
    old2 = 2 << (PB - 2); old4 = 5 << (PB - 4);
    new2 = 1 << (PB - 2); new4 = 12 << (PB - 4);
    press_wait(seen);
    wait_boundary(found);
    n_checks++;
    if (!seen || !found) begin n_fail++; $display("FAIL pwm_setup got seen %0b found %0b", seen, found); end
    hi2 = 0; hi4 = 0;
    repeat (256) begin @(posedge clk); #1; hi2 += int'(pwm2); hi4 += int'(pwm4); end
    n_checks++;
    if (hi2 != old2 || hi4 != old4) begin
      n_fail++; $display("FAIL pwm_duty got %0d/%0d exp %0d/%0d", hi2, hi4, old2, old4);
    end
    // Change the result mid-period: this period keeps the old duty.
    hi2 = 0; hi4 = 0;
    fork
      repeat (256) begin @(posedge clk); #1; hi2 += int'(pwm2); hi4 += int'(pwm4); end
      begin
        repeat (100) @(negedge clk);
        a2 = 2'd1; a4 = 4'd12;
        press_wait(seen);
      end
    join
    n_checks++;
    if (!seen || hi2 != old2 || hi4 != old4) begin
      n_fail++; $display("FAIL pwm_midperiod got %0d/%0d exp %0d/%0d", hi2, hi4, old2, old4);
    end
    hi2 = 0; hi4 = 0;
    repeat (256) begin @(posedge clk); #1; hi2 += int'(pwm2); hi4 += int'(pwm4); end
    n_checks++;
    if (hi2 != new2 || hi4 != new4) begin
      n_fail++; $display("FAIL pwm_newduty got %0d/%0d exp %0d/%0d", hi2, hi4, new2, new4);
    end
  endtask

  task automatic test_clear;
    bit seen, got_exec, found;
    int pulses, hi2;
    logic [19:0] m2;
    op = 3'd0; a2 = 2'd1; b2 = 2'd1; a4 = 4'd1; b4 = 4'd1;
    @(negedge clk); btn = 1'b1;
    got_exec = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (busy2 && !rv2) begin got_exec = 1; break; end
    end
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    n_checks++;
    if (!got_exec || {obs2, rv2, busy2} !== 8'd0 || {obs4, rv4, busy4} !== 10'd0) begin
      n_fail++; $display("FAIL clear_exec got %b %b exp 0 0", {obs2, rv2, busy2}, {obs4, rv4, busy4});
    end
    pulses = 0;
    repeat (5) begin @(posedge clk); #1; pulses += int'(rv2); end
    n_checks++;
    if (pulses != 0) begin n_fail++; $display("FAIL clear_rv got %0d exp 0", pulses); end
    @(negedge clk); btn = 1'b0;
    wait_boundary(found);
    hi2 = 0;
    repeat (256) begin @(posedge clk); #1; hi2 += int'(pwm2); end
    n_checks++;
    if (!found || hi2 != 0) begin n_fail++; $display("FAIL pwm_zero got %0d exp 0", hi2); end
    op = 3'd6; a2 = 2'd3;
    m2 = model(2, 6, 3, 0);
    press_wait(seen);
    n_checks++;
    if (!seen || obs2 !== {m2[19:16], m2[1:0]}) begin
      n_fail++; $display("FAIL post_clear got %b exp %b", obs2, {m2[19:16], m2[1:0]});
    end
  endtask

  task automatic test_reset_mid_done;
    bit got_done, seen;
    logic [19:0] m4;
    op = 3'd7; a2 = 2'd3; a4 = 4'd15;
    @(negedge clk); btn = 1'b1;
    got_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (rv2) begin got_done = 1; break; end
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (!got_done || {obs2, rv2, busy2, pwm2} !== 9'd0 || {obs4, rv4, busy4, pwm4} !== 11'd0) begin
      n_fail++; $display("FAIL reset_async got %b %b exp 0 0", {obs2, rv2, busy2, pwm2}, {obs4, rv4, busy4, pwm4});
    end
    btn = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({obs4, rv4, busy4, pwm4} !== 11'd0) begin
      n_fail++; $display("FAIL reset_release got %b exp 0", {obs4, rv4, busy4, pwm4});
    end
    repeat (3) @(negedge clk);
    op = 3'd5; a4 = 4'd9;
    m4 = model(4, 5, 9, 0);
    press_wait(seen);
    n_checks++;
    if (!seen || obs4 !== {m4[19:16], m4[3:0]}) begin
      n_fail++; $display("FAIL post_reset got %b exp %b", obs4, {m4[19:16], m4[3:0]});
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_sub();
    test_random();
    test_hold_and_handshake();
    test_pwm();
    test_clear();
    test_reset_mid_done();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired after %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
